// File: rtl/rs232_tx_scheduler_pkg.sv
// Shared definitions for the RS-232 transmit scheduler: FSM states, frame
// constants and a parity helper.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rs232_tx_scheduler_if.sv
// Requester handshake and serial/status bundle of the RS-232 transmit scheduler.
interface rs232_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [IDW-1:0]       grant_id;
  logic                 op_bit;
  logic                 idle;
  logic                 start;
  logic                 stop;
  logic                 frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, grant_id, op_bit, idle, start, stop, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, grant_id, op_bit, idle, start, stop, frame_done
  );
endinterface

// File: rtl/rs232_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above rr_ptr,
// wrapping to the bottom of the vector.
module rs232_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_valid
);

  logic found;

  // Two passes give the wrap-around search without modulo arithmetic.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && (j >= int'(rr_ptr)) && req_valid[j]) begin
        found     = 1'b1;
        grant_idx = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && (j < int'(rr_ptr)) && req_valid[j]) begin
        found     = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

  assign any_valid = |req_valid;
  assign grant     = (enable && found) ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Shares one RS-232 transmitter between NUM_REQ byte requesters: round-robin
// grant, then start bit, 8 data bits LSB first, optional even parity, stop bit(s).
module rs232_tx_scheduler
  import rs232_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rs232_tx_scheduler_if.slave  bus
);

  localparam int             IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg, win_data;
  logic                 parity_bit;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic [IDW-1:0]       rr_ptr, grant_id, win_idx;
  logic [NUM_REQ-1:0]   win_grant;
  logic                 any_valid, arb_en, accept, bit_end;
  logic                 op_bit, idle, start, stop, frame_done;

  assign arb_en  = (state == IDLE);
  assign accept  = arb_en & any_valid;
  assign bit_end = (baud_cnt == BAUD_LAST);

  rs232_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_grant[j]) win_data = bus.req_data[DATA_BITS*j +: DATA_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_bit     = LINE_IDLE;
    idle       = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (accept) state_nxt = START;
      end
      START: begin
        op_bit = LINE_START;
        start  = 1'b1;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        op_bit = shift_reg[0];
        if (bit_end && bit_cnt == BIT_LAST)
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        op_bit = parity_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        stop = 1'b1;
        if (bit_end && stop_cnt == STOP_LAST) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters run only while a frame is in flight; IDLE parks them at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      rr_ptr     <= '0;
      grant_id   <= '0;
    end else begin
      if (accept) begin
        shift_reg  <= win_data;
        parity_bit <= even_parity(win_data);
        grant_id   <= win_idx;
        rr_ptr     <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (state == DATA && bit_end) begin
        shift_reg <= {LINE_IDLE, shift_reg[DATA_BITS-1:1]};
      end

      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;

      if (state == IDLE)                bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;

      if (state == IDLE)                stop_cnt <= 1'b0;
      else if (state == STOP && bit_end) stop_cnt <= stop_cnt + 1'b1;
    end
  end

  assign bus.req_ready  = win_grant;
  assign bus.grant_id   = grant_id;
  assign bus.op_bit     = op_bit;
  assign bus.idle       = idle;
  assign bus.start      = start;
  assign bus.stop       = stop;
  assign bus.frame_done = frame_done;

endmodule

// File: doc/rs232_tx_scheduler.md
Name: rs232_tx_scheduler

Overview:
Sequences one RS-232 serial transmit datapath and shares it between NUM_REQ byte requesters.
- Round-robin arbitration picks one requester and latches its byte.
- Frames the byte as start bit, 8 data bits LSB first, optional even parity, then stop bit(s), at a fixed CLKS_PER_BIT rate.
- Sits between on-chip byte producers and the serial line driver.
- Exports idle/start/stop status flags and the op_bit serial output.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..8.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  bit i set = requester i offers a byte.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of the requester currently being sent.
- op_bit  out  1  serial line; high when idle.
- idle  out  1  high in IDLE state.
- start  out  1  high during the start bit.
- stop  out  1  high during the stop bit(s).
- frame_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset (asynchronous, any time including mid-frame) forces the following state:
  - op_bit=1, idle=1, start=0, stop=0, req_ready=0, frame_done=0.
  - grant_id=0, rr_ptr=0, state=IDLE, baud and bit counters=0.
  - Any partially sent byte is discarded.
- State machine is IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle. It is combinational from req_valid and state, and high only in IDLE.
  - On that edge: shift register <= req_data[winner], grant_id <= winner, rr_ptr <= (winner+1) mod NUM_REQ, state <= START.
- Requester handshake:
  - Data transfers only on a cycle where req_valid[i] & req_ready[i].
  - A requester may deassert valid before ready with no effect.
- START: op_bit=0, start=1, for exactly CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, each held CLKS_PER_BIT cycles, LSB first. op_bit = shift_reg[0].
  - The register shifts right at each bit boundary.
  - A 3-bit counter selects the exit after bit 7.
- PARITY (PARITY_EN=1 only): op_bit = XOR of the 8 latched bits, for CLKS_PER_BIT cycles.
- STOP:
  - op_bit=1, stop=1, for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle, then state <= IDLE.
- Frame length, from the first START cycle to the last STOP cycle inclusive: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Gap between frames: at least one IDLE cycle, even with requests pending. In that cycle op_bit=1, idle=1, stop=0, and the next grant is made.
- Status flags: idle, start and stop are mutually exclusive; all three are 0 during DATA and PARITY.
- Baud counter counts 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is cleared in IDLE.
- grant_id holds its value until the next grant.
- The latched byte is unaffected by req_data changes after acceptance.
- NUM_REQ=1: grant_id is constant 0 and rr_ptr is unused.

Decomposition:
- Shared package rs232_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - DATA_BITS=8, line idle level 1, start level 0.
- One sub-module: rs232_rr_arbiter (NUM_REQ).
  - Inputs: req_valid, rr_ptr, enable.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Purely combinational.
- The pointer register lives in the scheduler.

Test Plan:
- Reset then idle, no requests: op_bit=1, idle=1 indefinitely, req_ready=0.
- Single byte, defaults (CLKS_PER_BIT=16):
  - Stimulus: req_valid=4'b0001, data 8'hA5.
  - req_ready[0] pulses for 1 cycle.
  - Line, sampled mid-bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - frame_done pulses exactly 160 cycles after the first START cycle.
- Round-robin fairness:
  - All four valid continuously, distinct bytes 8'h11/8'h22/8'h33/8'h44.
  - Grants go 0,1,2,3,0, with exactly one IDLE cycle between frames.
- Fairness with a re-requester:
  - Requester 2 re-asserts immediately while 3 is pending.
  - Requester 3 wins next.
- Parity and framing (PARITY_EN=1, STOP_BITS=2):
  - Byte 8'h07 yields parity bit 1.
  - Frame length is 12*CLKS_PER_BIT cycles; stop high for 32 cycles.
- Reset mid-frame:
  - Assert rst_n=0 during DATA bit 3, asynchronously with no clock edge.
  - op_bit=1 and idle=1 immediately.
  - After release, the next grant begins searching from requester 0.
